window_fetch_ctrl: RTL

- Read-side sequencer for the 2-D interleaved tile RAM that stores the camera tile ahead of the CNN datapath.
- Scans a T_WIDTH x T_WIDTH tile in raster order with a configurable stride and issues one read per window position; each read returns a full I_WIDTH x I_WIDTH window in one beat.
- Absorbs the RAM's fixed read latency and delivers windows to the convolution stage on a valid/ready stream with full backpressure.
- Window data is never lost and reads are never stalled inside the RAM.

---
 rtl/window_fetch_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/window_fetch_ctrl.sv
// Raster-scan read sequencer for the interleaved tile RAM, with credit-based issue and a FWFT
// window FIFO. Define WFC_COORD_EN to add win_y/win_x coordinate outputs.
module window_fetch_ctrl #(
  parameter int unsigned I_WIDTH    = 2,
  parameter int unsigned T_WIDTH    = 32,
  parameter int unsigned D_SIZE     = 16,
  parameter int unsigned STRIDE     = 1,
  parameter int unsigned READ_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              ram_re,
  output logic [$clog2(T_WIDTH)-1:0]        ram_addr_y,
  output logic [$clog2(T_WIDTH)-1:0]        ram_addr_x,
  input  logic [I_WIDTH*I_WIDTH*D_SIZE-1:0] ram_dout,
  output logic [I_WIDTH*I_WIDTH*D_SIZE-1:0] win_data,
  output logic                              win_valid,
  input  logic                              win_ready,
`ifdef WFC_COORD_EN
  output logic [$clog2(T_WIDTH)-1:0]        win_y,
  output logic [$clog2(T_WIDTH)-1:0]        win_x,
`endif
  output logic                              win_last
);

  localparam int unsigned T_LOG  = $clog2(T_WIDTH);
  localparam int unsigned W_DATA = I_WIDTH * I_WIDTH * D_SIZE;
  localparam int unsigned N_POS  = (T_WIDTH - I_WIDTH) / STRIDE + 1;
  // The issue cycle is the first of the READ_LAT cycles, so READ_LAT >= 2 is required.
  localparam int unsigned PIPE   = READ_LAT - 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
`ifdef WFC_COORD_EN
  localparam int unsigned TAG_W  = 1 + 2 * T_LOG;
`else
  localparam int unsigned TAG_W  = 1;
`endif
  localparam int unsigned ENT_W  = TAG_W + W_DATA;

  localparam logic [T_LOG-1:0] MaxPos  = T_LOG'((N_POS - 1) * STRIDE);
  localparam logic [T_LOG-1:0] Step    = T_LOG'(STRIDE);
  localparam logic [CNT_W-1:0] Depth   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LastPtr = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e             state_q, state_d;
  logic [T_LOG-1:0]   y_q, y_d, x_q, x_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PIPE-1:0]    pipe_vld_q, pipe_vld_d;
  logic [TAG_W-1:0]   pipe_tag_q [PIPE];
  logic [TAG_W-1:0]   pipe_tag_d [PIPE];
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [TAG_W-1:0]   issue_tag;
  logic [ENT_W-1:0]   head;
  logic [CNT_W:0]     outstanding;
  logic               fifo_wr, fifo_rd;

  // Credit covers both buffered windows and reads still inside the RAM.
  assign outstanding = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign ram_re      = (state_q == StIssue) && (outstanding < {1'b0, Depth});
  assign ram_addr_y  = y_q;
  assign ram_addr_x  = x_q;
  assign busy        = (state_q != StIdle);

  always_comb begin
    issue_tag    = '0;
    issue_tag[0] = (y_q == MaxPos) && (x_q == MaxPos);
`ifdef WFC_COORD_EN
    issue_tag[TAG_W-1:1] = {y_q, x_q};
`endif
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    x_d     = x_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          y_d     = '0;
          x_d     = '0;
        end
      end
      StIssue: begin
        if (ram_re) begin
          if (x_q == MaxPos) begin
            x_d = '0;
            if (y_q == MaxPos) begin
              y_d     = '0;
              state_d = StDrain;
            end else begin
              y_d = y_q + Step;
            end
          end else begin
            x_d = x_q + Step;
          end
        end
      end
      StDrain: begin
        // Every read was issued, so an empty pipe and FIFO means the last window has left.
        if ((inflight_q == '0) && (fifo_cnt_q == '0)) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_vld_d[0] = ram_re;
    pipe_tag_d[0] = issue_tag;
    for (int i = 1; i < PIPE; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  assign fifo_wr   = pipe_vld_q[PIPE-1];
  assign win_valid = (fifo_cnt_q != '0);
  assign fifo_rd   = win_valid && win_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    inflight_d = inflight_q;
    if (fifo_wr) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (fifo_rd) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    if (fifo_wr && !fifo_rd)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!fifo_wr && fifo_rd) fifo_cnt_d = fifo_cnt_q - 1'b1;
    if (ram_re && !fifo_wr)       inflight_d = inflight_q + 1'b1;
    else if (!ram_re && fifo_wr)  inflight_d = inflight_q - 1'b1;
  end

  assign head     = mem_q[rd_ptr_q];
  assign win_data = head[W_DATA-1:0];
  assign win_last = win_valid && head[W_DATA];
`ifdef WFC_COORD_EN
  assign win_x    = head[W_DATA+1 +: T_LOG];
  assign win_y    = head[W_DATA+1+T_LOG +: T_LOG];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      y_q        <= '0;
      x_q        <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < PIPE; i++) pipe_tag_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      x_q        <= x_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < PIPE; i++) pipe_tag_q[i] <= pipe_tag_d[i];
      if (fifo_wr) mem_q[wr_ptr_q] <= {pipe_tag_q[PIPE-1], ram_dout};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr && (fifo_cnt_q == Depth)));

endmodule
